// File: rtl/tx_sync111_if.sv
// Frame-request / serial-line bundle between a frame source and the tx_sync111 transmitter.
// The source drives start/data; the transmitter drives x/busy/done.
interface tx_sync111_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              x;
  logic              busy;
  logic              done;

  modport master (output start, output data, input x, input busy, input done);
  modport slave  (input start, input data, output x, output busy, output done);
endinterface

// File: rtl/tx_sync111.sv
// Serial frame transmitter for the "111" detector link: a sync run of ones, a zero separator,
// a bit-stuffed MSB-first payload, then a zero tail bit.
module tx_sync111 #(
  parameter int DATA_W   = 8,
  parameter int SYNC_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  tx_sync111_if.slave  bus
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(SYNC_LEN + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN);
  localparam logic [CW-1:0] ONES_MAX  = CW'(SYNC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEP,
    S_DATA,
    S_STUFF,
    S_TAIL
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_shift_left;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic [BW-1:0]     w_bit_inc;
  logic [CW-1:0]     r_sync_cnt;
  logic [CW-1:0]     w_sync_cnt_nxt;
  logic [CW-1:0]     r_ones_cnt;
  logic [CW-1:0]     w_ones_cnt_nxt;
  logic [CW-1:0]     w_ones_upd;
  logic              w_bit;
  logic              w_x_nxt;
  logic              r_x;
  logic              r_busy;
  logic              r_done;

  assign w_bit        = r_shift[DATA_W-1];
  assign w_shift_left = {r_shift[DATA_W-2:0], 1'b0};
  assign w_bit_inc    = r_bit_cnt + 1'b1;
  assign w_ones_upd   = w_bit ? (r_ones_cnt + 1'b1) : '0;

  // Outputs are registered from the next-state decode, so x/busy/done change right after the edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sync_cnt_nxt = r_sync_cnt;
    w_ones_cnt_nxt = r_ones_cnt;
    w_x_nxt        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_SYNC;
          w_shift_nxt    = bus.data;
          w_sync_cnt_nxt = CW'(1);
          w_x_nxt        = 1'b1;
        end
      end
      S_SYNC: begin
        if (r_sync_cnt == SYNC_LAST) begin
          w_state_nxt = S_SEP;
        end else begin
          w_sync_cnt_nxt = r_sync_cnt + 1'b1;
          w_x_nxt        = 1'b1;
        end
      end
      S_SEP: begin
        w_state_nxt    = S_DATA;
        w_bit_cnt_nxt  = '0;
        w_ones_cnt_nxt = '0;
        w_x_nxt        = w_bit;
      end
      S_DATA: begin
        w_shift_nxt    = w_shift_left;
        w_bit_cnt_nxt  = w_bit_inc;
        w_ones_cnt_nxt = w_ones_upd;
        // The tail bit is already 0, so a run ending on the last payload bit needs no stuff.
        if (w_bit_inc == BITS_LAST) begin
          w_state_nxt = S_TAIL;
        end else if (w_ones_upd == ONES_MAX) begin
          w_state_nxt = S_STUFF;
        end else begin
          w_x_nxt = w_shift_left[DATA_W-1];
        end
      end
      S_STUFF: begin
        w_state_nxt    = S_DATA;
        w_ones_cnt_nxt = '0;
        w_x_nxt        = w_bit;
      end
      S_TAIL: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_sync_cnt <= '0;
      r_ones_cnt <= '0;
      r_x        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_ones_cnt <= w_ones_cnt_nxt;
      r_x        <= w_x_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_TAIL);
    end
  end

  // Payload shifter is only read in SEP/DATA/STUFF, after a load on acceptance.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign bus.x    = r_x;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
